// File: rtl/lut_multiplier_radix4_seq_pkg.sv
// Shared types and constants for the radix-4 LUT multiplier.
package lut_mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Radix-4 digit codes selecting 0, A, 2A or 3A.
    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    // Number of 2-bit multiplier digits.
    function automatic int ndig(input int b_width);
        return b_width / 2;
    endfunction

    // Full-precision product width.
    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

endpackage

// File: rtl/lut_multiplier_radix4_seq_if.sv
// Start/busy/done handshake and operand/result bus of the radix-4 multiplier.
interface lut_multiplier_radix4_seq_if #(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 8
);
    logic                       start_mr;
    logic [A_WIDTH-1:0]         source_number_mr_0;
    logic [B_WIDTH-1:0]         source_number_mr_1;
    logic                       busy_mr;
    logic                       done_mr;
    logic [A_WIDTH+B_WIDTH-1:0] result_mr;

    modport master (
        output start_mr, source_number_mr_0, source_number_mr_1,
        input  busy_mr, done_mr, result_mr
    );

    modport slave (
        input  start_mr, source_number_mr_0, source_number_mr_1,
        output busy_mr, done_mr, result_mr
    );
endinterface

// File: rtl/lut_multiplier_radix4_seq_pp.sv
// Combinational 2-bit partial-product lookup: 0, A, 2A or 3A.
module lut_pp_2b
    import lut_mult_pkg::*;
#(
    parameter int A_WIDTH = 4
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [1:0]         d,
    output logic [A_WIDTH+1:0] pp
);
    logic [A_WIDTH+1:0] a_x1;
    logic [A_WIDTH+1:0] a_x2;

    assign a_x1 = {2'b00, a};
    assign a_x2 = {1'b0, a, 1'b0};

    // Select the multiple of A named by the current digit.
    always_comb begin
        pp = '0;
        case (d)
            D0:      pp = '0;
            D1:      pp = a_x1;
            D2:      pp = a_x2;
            D3:      pp = a_x1 + a_x2;
            default: pp = '0;
        endcase
    end
endmodule

// File: rtl/lut_multiplier_radix4_seq.sv
// Sequential unsigned multiplier retiring two multiplier bits per clock.
module lut_multiplier_radix4_seq
    import lut_mult_pkg::*;
#(
    parameter int A_WIDTH    = 4,
    parameter int B_WIDTH    = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                  clk_mr,
    input  logic                  resetn_mr,
    lut_multiplier_radix4_seq_if.slave bus
);
    localparam int NDIG = ndig(B_WIDTH);
    localparam int PW   = prod_width(A_WIDTH, B_WIDTH);
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    generate
        if ((B_WIDTH % 2) != 0 || B_WIDTH < 2) begin : g_bad_b_width
            $error("lut_multiplier_radix4_seq: B_WIDTH must be even and >= 2");
        end
        if (A_WIDTH < 1) begin : g_bad_a_width
            $error("lut_multiplier_radix4_seq: A_WIDTH must be >= 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [PW-1:0]      acc_q;
    logic [KW-1:0]      k_q;
    logic [PW-1:0]      res_q;
    logic               done_q;
    logic               busy_q;

    logic [A_WIDTH+1:0] pp;
    logic [PW-1:0]      pp_sh;
    logic [PW-1:0]      acc_nxt;
    logic               last;

    lut_pp_2b #(.A_WIDTH(A_WIDTH)) u_pp (
        .a  (a_q),
        .d  (b_q[1:0]),
        .pp (pp)
    );

    assign pp_sh   = PW'(pp) << {k_q, 1'b0};
    assign acc_nxt = acc_q + pp_sh;
    // Early exit fires once every digit above the current one is zero.
    assign last    = (k_q == K_LAST) || ((EARLY_EXIT != 0) && ((b_q >> 2) == '0));

    // State register.
    always_ff @(posedge clk_mr or negedge resetn_mr) begin
        if (!resetn_mr) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state: start only honoured in IDLE, RUN leaves on the last digit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_mr) state_d = RUN;
            RUN:     if (last)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, shift-and-accumulate, and registered result/handshake.
    always_ff @(posedge clk_mr or negedge resetn_mr) begin
        if (!resetn_mr) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_mr) begin
                        a_q    <= bus.source_number_mr_0;
                        b_q    <= bus.source_number_mr_1;
                        acc_q  <= '0;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    b_q   <= b_q >> 2;
                    k_q   <= k_q + KW'(1);
                    if (last) begin
                        res_q  <= acc_nxt;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_mr   = busy_q;
    assign bus.done_mr   = done_q;
    assign bus.result_mr = res_q;
endmodule
